control_sequencer: RTL and testbench

//  Multi-cycle control unit sitting directly upstream of Datapath; replaces the hand-driven
//  T0..T6 control stimulus. Runs fetch (T0-T2), decodes IR from the datapath, then emits
//  the per-step control strobes for reg-reg ALU, mul/div, unary, nop and halt instructions.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/reg_field_decoder.sv | 16 +
 rtl/control_sequencer.sv | 179 +++++++++++++++++
 tb/tb_control_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control unit: instruction field layout,
// opcode values, FSM state encoding and the opcode-to-instruction-class decode.
package cpu_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;
  localparam int OPC_W    = 5;
  localparam int OPC_LSB  = 27;
  localparam int RA_LSB   = 23;
  localparam int RB_LSB   = 19;
  localparam int RC_LSB   = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [OPC_W-1:0] opc);
    instr_class_e cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:  cls = CLS_ALU;
      OP_MUL, OP_DIV:           cls = CLS_MULDIV;
      OP_NEG, OP_NOT:           cls = CLS_UNARY;
      OP_NOP:                   cls = CLS_NOP;
      OP_HALT:                  cls = CLS_HALT;
      default:                  cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field to one-hot register enable; all zeros when not enabled.
module reg_field_decoder
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]    field_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // NOTE: the default assignment ahead of the if keeps this purely combinational (no latch).
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[field_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch T0-T2, decode IR in T3, then per-class
// execute strobes. Outputs are decoded from the registered state and IR.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    operation,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                halted
);

  state_e             state_q, state_d;
  logic               t1_first_q;
  logic [OPC_W-1:0]   opc;
  instr_class_e       cls;
  state_e             end_state;
  logic               rin_en, rout_en;
  logic [REG_W-1:0]   rout_field;
  logic               unused_ir;

  assign opc        = ir[OPC_LSB +: OPC_W];
  assign cls        = classify(opc);
  assign end_state  = run ? S_T0 : S_IDLE;
  assign unused_ir  = ^ir[RC_LSB-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV, CLS_UNARY: state_d = S_T4;
          CLS_HALT:                       state_d = S_HALT;
          default:                        state_d = end_state;
        endcase
      end
      S_T4:   state_d = (cls == CLS_UNARY) ? end_state : S_T5;
      S_T5:   state_d = (cls == CLS_MULDIV) ? S_T6 : end_state;
      S_T6:   state_d = end_state;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      t1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t1_first_q <= (state_q == S_T0);
    end
  end

  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    rin_en     = 1'b0;
    rout_en    = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      // PC update happens once; the memory read strobes stay up across wait cycles.
      S_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = t1_first_q;
        Zlowout = t1_first_q;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
          end
          CLS_UNARY: begin
            rout_en = 1'b1;
            Zin     = 1'b1;
          end
          CLS_NOP, CLS_HALT: instr_done = 1'b1;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_T4: begin
        if (cls == CLS_UNARY) begin
          Zlowout    = 1'b1;
          rin_en     = 1'b1;
          instr_done = 1'b1;
        end else begin
          rout_en = 1'b1;
          Zin     = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          rin_en     = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign operation  = Zin ? opc : '0;
  assign rout_field = (state_q == S_T4) ? ir[RC_LSB +: REG_W] : ir[RB_LSB +: REG_W];

  reg_field_decoder u_rin_dec (
    .field_i  (ir[RA_LSB +: REG_W]),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_field_decoder u_rout_dec (
    .field_i  (rout_field),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: stimulus pushes hand-computed per-cycle control words into a
// scoreboard queue; a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

  typedef struct packed {
    logic        pc_out, pc_in, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
    logic [15:0] rin, rout;
    logic [4:0]  op;
    logic        done, ill, hlt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1, run = 1'b0, mem_ready = 1'b1;
  logic [31:0] ir = '0;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  operation;
  logic        instr_done, illegal_op, halted;

  ctl_t        act;
  ctl_t        exp_q[$];
  string       name_q[$];
  ctl_t        mon_e;
  string       mon_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_ir = '0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .Clock(clk), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .operation(operation), .instr_done(instr_done),
    .illegal_op(illegal_op), .halted(halted)
  );

  assign act = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin, Rin, Rout,
                operation, instr_done, illegal_op, halted};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_n, act, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  // One clock cycle: drive inputs for this cycle and queue the outputs expected in it.
  task automatic cyc(input logic clr, input logic rn, input logic mr,
                     input bit chk, input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    clear     = clr;
    run       = rn;
    mem_ready = mr;
    ir        = cur_ir;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic fetch(input logic [31:0] irv, input int waits);
    ctl_t e;
    cur_ir = irv;
    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; e.op = irv[31:27];
    cyc(0, 1, 1, 1, e, "T0");
    for (int i = 0; i <= waits; i++) begin
      e = '0; e.rd = 1; e.mdr_in = 1;
      if (i == 0) begin e.pc_in = 1; e.zlo_out = 1; end
      cyc(0, 1, (i == waits), 1, e, "T1");
    end
    e = '0; e.mdr_out = 1; e.ir_in = 1;
    cyc(0, 1, 1, 1, e, "T2");
  endtask

  task automatic exec_alu(input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                          input logic [15:0] ra_oh, input logic [4:0] op);
    ctl_t e;
    e = '0; e.rout = rb_oh; e.y_in = 1;                 cyc(0, 1, 1, 1, e, "alu_T3");
    e = '0; e.rout = rc_oh; e.z_in = 1; e.op = op;      cyc(0, 1, 1, 1, e, "alu_T4");
    e = '0; e.zlo_out = 1; e.rin = ra_oh; e.done = 1;   cyc(0, 1, 1, 1, e, "alu_T5");
  endtask

  task automatic exec_muldiv(input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                             input logic [4:0] op);
    ctl_t e;
    e = '0; e.rout = rb_oh; e.y_in = 1;                 cyc(0, 1, 1, 1, e, "md_T3");
    e = '0; e.rout = rc_oh; e.z_in = 1; e.op = op;      cyc(0, 1, 1, 1, e, "md_T4");
    e = '0; e.zlo_out = 1; e.lo_in = 1;                 cyc(0, 1, 1, 1, e, "md_T5");
    e = '0; e.zhi_out = 1; e.hi_in = 1; e.done = 1;     cyc(0, 1, 1, 1, e, "md_T6");
  endtask

  task automatic exec_unary(input logic [15:0] rb_oh, input logic [15:0] ra_oh,
                            input logic [4:0] op);
    ctl_t e;
    e = '0; e.rout = rb_oh; e.z_in = 1; e.op = op;      cyc(0, 1, 1, 1, e, "un_T3");
    e = '0; e.zlo_out = 1; e.rin = ra_oh; e.done = 1;   cyc(0, 1, 1, 1, e, "un_T4");
  endtask

  task automatic exec_t3(input logic ill, input logic run_end);
    ctl_t e;
    e = '0; e.done = 1; e.ill = ill;
    cyc(0, run_end, 1, 1, e, "T3_only");
  endtask

  initial begin
    ctl_t e;
    // Reset and leave IDLE.
    cyc(1, 0, 1, 0, '0, "");
    cyc(0, 0, 1, 1, '0, "reset_idle");
    cyc(0, 1, 1, 1, '0, "idle_run");

    fetch(32'h1891_8000, 0);                       // add R1,R2,R3
    exec_alu(16'h0004, 16'h0008, 16'h0002, 5'b00011);
    fetch(mk(5'b00100, 4'd15, 4'd0, 4'd9), 3);     // sub R15,R0,R9 with 3 wait cycles
    exec_alu(16'h0001, 16'h0200, 16'h8000, 5'b00100);
    fetch(mk(5'b01111, 4'd5, 4'd6, 4'd7), 0);      // mul Rb=6,Rc=7 (Ra ignored)
    exec_muldiv(16'h0040, 16'h0080, 5'b01111);
    fetch(mk(5'b10001, 4'd4, 4'd5, 4'd0), 0);      // neg R4,R5
    exec_unary(16'h0020, 16'h0010, 5'b10001);
    fetch(mk(5'b10000, 4'd0, 4'd15, 4'd0), 1);     // div R15,R0
    exec_muldiv(16'h8000, 16'h0001, 5'b10000);
    fetch(mk(5'b10010, 4'd0, 4'd15, 4'd0), 0);     // not R0,R15
    exec_unary(16'h8000, 16'h0001, 5'b10010);
    fetch(mk(5'b11010, 4'd0, 4'd0, 4'd0), 0);      // nop
    exec_t3(1'b0, 1'b1);
    fetch(mk(5'b11111, 4'd2, 4'd3, 4'd4), 0);      // illegal, run dropped -> IDLE
    exec_t3(1'b1, 1'b0);
    cyc(0, 0, 1, 1, '0, "idle_after_illegal");
    cyc(0, 1, 1, 1, '0, "idle_restart");

    // clear in the middle of an add's T4.
    fetch(mk(5'b00011, 4'd3, 4'd14, 4'd0), 0);
    e = '0; e.rout = 16'h4000; e.y_in = 1;             cyc(0, 1, 1, 1, e, "clr_T3");
    e = '0; e.rout = 16'h0001; e.z_in = 1; e.op = 5'b00011;
    cyc(1, 1, 1, 1, e, "clr_T4");
    cyc(0, 0, 1, 1, '0, "after_clear");
    cyc(0, 1, 1, 1, '0, "after_clear_idle");

    // halt holds until clear, even with run asserted.
    fetch(mk(5'b11011, 4'd0, 4'd0, 4'd0), 0);
    exec_t3(1'b0, 1'b1);
    e = '0; e.hlt = 1;
    cyc(0, 1, 1, 1, e, "halted_1");
    cyc(0, 1, 1, 1, e, "halted_2");
    cyc(1, 1, 1, 1, e, "halted_3");
    cyc(0, 0, 1, 1, '0, "halt_cleared");

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
